fpu_subtractor: RTL and testbench



---
 rtl/fpu_pkg.sv | 58 +++++
 rtl/fpu_align_shifter.sv | 22 ++
 rtl/fpu_subtractor.sv | 215 +++++++++++++++++++++
 tb/tb_fpu_subtractor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types, constants and pack/unpack helpers for the FPU subtractor datapath.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int WORK_W = 27;

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [31:0]      POS_INF = 32'h7F800000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_OPER   = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // Working mantissa layout: {hidden 1, frac[22:0], guard, round, sticky}
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic [WORK_W-1:0] man;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } operand_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [WORK_W-1:0] man;
    } work_t;

    function automatic operand_t unpack_operand(input logic [31:0] value, input logic flip_sign);
        operand_t op;
        op.sign    = value[31] ^ flip_sign;
        op.exp     = value[30:23];
        op.frac    = value[22:0];
        op.man     = {1'b1, value[22:0], 3'b000};
        op.is_zero = (value[30:23] == '0);
        op.is_inf  = (value[30:23] == EXP_MAX) && (value[22:0] == '0);
        op.is_nan  = (value[30:23] == EXP_MAX) && (value[22:0] != '0);
        return op;
    endfunction

    function automatic logic [31:0] pack_fp(input logic sign, input logic [EXP_W-1:0] exp,
                                            input logic [FRAC_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

    function automatic logic [31:0] signed_inf(input logic sign);
        return {sign, POS_INF[30:0]};
    endfunction

endpackage

// File: rtl/fpu_align_shifter.sv
// Combinational right barrel shift of a working mantissa; every bit shifted out ORs into the sticky LSB.
module fpu_align_shifter #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0] mantissa,
    input  logic [7:0]       amount,
    output logic [WIDTH-1:0] aligned
);

    logic [2*WIDTH-1:0] wide;

    // Upper half is the shifted mantissa, lower half collects what fell off the end.
    always_comb begin
        wide = {mantissa, {WIDTH{1'b0}}} >> amount;
        if (amount >= 8'(WIDTH)) begin
            aligned = {{(WIDTH-1){1'b0}}, |mantissa};
        end else begin
            aligned = {wide[2*WIDTH-1:WIDTH+1], wide[WIDTH] | (|wide[WIDTH-1:0])};
        end
    end

endmodule

// File: rtl/fpu_subtractor.sv
// Multicycle IEEE-754 single-precision subtractor (result = a - b) with iterative normalization.
// Define FPU_SUB_ROUND_EN for round-to-nearest-even; otherwise ROUND truncates.
module fpu_subtractor
    import fpu_pkg::*;
#(
    parameter int MAX_NORM_STEPS = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int CNT_W = $clog2(MAX_NORM_STEPS + 1);
    localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_NORM_STEPS);

    logic [2:0]        state;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    work_t             op_a;
    work_t             op_b;
    logic              res_sign;
    logic [EXP_W-1:0]  res_exp;
    logic [WORK_W-1:0] man_larger;
    logic [WORK_W-1:0] man_smaller;
    logic [WORK_W-1:0] man;
    logic              eff_sub;
    logic [CNT_W-1:0]  norm_steps;

    operand_t          ua;
    operand_t          ub;
    logic              special;
    logic [31:0]       special_res;
    logic              a_larger;
    work_t             larger;
    work_t             smaller;
    logic [7:0]        exp_diff;
    logic [WORK_W-1:0] smaller_aligned;
    logic [WORK_W:0]   sum;
    logic [WORK_W-1:0] diff;
    logic              inc;
    logic [24:0]       rounded;

    assign busy = (state != S_IDLE);

    assign ua = unpack_operand(a_reg, 1'b0);
    assign ub = unpack_operand(b_reg, 1'b1);

    // NaN wins, then infinities, then zero operands; denormals count as zero.
    always_comb begin
        special     = 1'b1;
        special_res = '0;
        if (ua.is_nan || ub.is_nan) begin
            special_res = QNAN;
        end else if (ua.is_inf && ub.is_inf) begin
            special_res = (ua.sign == ub.sign) ? signed_inf(ua.sign) : QNAN;
        end else if (ua.is_inf) begin
            special_res = signed_inf(ua.sign);
        end else if (ub.is_inf) begin
            special_res = signed_inf(ub.sign);
        end else if (ua.is_zero && ub.is_zero) begin
            special_res = {ua.sign & ub.sign, 31'b0};
        end else if (ua.is_zero) begin
            special_res = pack_fp(ub.sign, ub.exp, ub.frac);
        end else if (ub.is_zero) begin
            special_res = pack_fp(ua.sign, ua.exp, ua.frac);
        end else begin
            special = 1'b0;
        end
    end

    always_comb begin
        a_larger = ({op_a.exp, op_a.man} >= {op_b.exp, op_b.man});
        if (a_larger) begin
            larger  = op_a;
            smaller = op_b;
        end else begin
            larger  = op_b;
            smaller = op_a;
        end
        exp_diff = larger.exp - smaller.exp;
    end

    fpu_align_shifter #(
        .WIDTH(WORK_W)
    ) u_align (
        .mantissa(smaller.man),
        .amount  (exp_diff),
        .aligned (smaller_aligned)
    );

    assign sum  = {1'b0, man_larger} + {1'b0, man_smaller};
    assign diff = man_larger - man_smaller;

`ifdef FPU_SUB_ROUND_EN
    assign inc = man[2] & (man[1] | man[0] | man[3]);
`else
    assign inc = 1'b0;
`endif

    assign rounded = {1'b0, man[26:3]} + {24'b0, inc};

    // Main control: done is registered together with the entry into DONE, so it lasts exactly that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            result      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            res_sign    <= 1'b0;
            res_exp     <= '0;
            man_larger  <= '0;
            man_smaller <= '0;
            man         <= '0;
            eff_sub     <= 1'b0;
            norm_steps  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (special) begin
                        result <= special_res;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        op_a  <= '{ua.sign, ua.exp, ua.man};
                        op_b  <= '{ub.sign, ub.exp, ub.man};
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    res_sign    <= larger.sign;
                    res_exp     <= larger.exp;
                    man_larger  <= larger.man;
                    man_smaller <= smaller_aligned;
                    eff_sub     <= (larger.sign != smaller.sign);
                    state       <= S_OPER;
                end
                S_OPER: begin
                    norm_steps <= '0;
                    if (!eff_sub) begin
                        if (sum[WORK_W]) begin
                            if (res_exp == EXP_MAX - 8'd1) begin
                                result <= signed_inf(res_sign);
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                man     <= {sum[WORK_W:2], sum[1] | sum[0]};
                                res_exp <= res_exp + 8'd1;
                                state   <= S_NORM;
                            end
                        end else begin
                            man   <= sum[WORK_W-1:0];
                            state <= S_NORM;
                        end
                    end else if (diff == '0) begin
                        result <= '0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        man   <= diff;
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (man[WORK_W-1]) begin
                        state <= S_ROUND;
                    end else if ((res_exp > 8'd1) && (norm_steps < STEP_LIMIT)) begin
                        man        <= {man[WORK_W-2:0], 1'b0};
                        res_exp    <= res_exp - 8'd1;
                        norm_steps <= norm_steps + CNT_W'(1);
                    end else begin
                        result <= '0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_ROUND: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                    if (rounded[24]) begin
                        if (res_exp == EXP_MAX - 8'd1) begin
                            result <= signed_inf(res_sign);
                        end else begin
                            result <= pack_fp(res_sign, res_exp + 8'd1, rounded[23:1]);
                        end
                    end else begin
                        result <= pack_fp(res_sign, res_exp, rounded[22:0]);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_subtractor.sv
// Directed self-checking bench for fpu_subtractor: results, latency, specials, control and reset abort.
module tb_fpu_subtractor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    int          cycles;
    logic [31:0] res;
    logic        busy_ok;
    logic        done_seen;

`ifdef FPU_SUB_ROUND_EN
    localparam logic [31:0] ROUND_EXPECT = 32'h3F800000;
`else
    localparam logic [31:0] ROUND_EXPECT = 32'h3F7FFFFF;
`endif

    fpu_subtractor dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Cycle 1 is the cycle start is high; cycles counts up to the cycle in which done is seen.
    task automatic apply_stimulus(input logic [31:0] va, input logic [31:0] vb, input int inject_at,
                                  output int n, output logic [31:0] r, output logic ok);
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        n     = 1;
        ok    = 1'b1;
        r     = '0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == inject_at);
            if (n == inject_at) begin
                a = 32'h3F800000;
                b = 32'h3F800000;
            end
            if (done) begin
                r = result;
                break;
            end
            if (!busy) ok = 1'b0;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input string tag, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] expected, input int exp_cycles);
        int          n;
        logic [31:0] r;
        logic        ok;
        apply_stimulus(va, vb, 0, n, r, ok);
        check_output({tag, "_result"}, r, expected);
        check_output({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_done", {31'b0, done}, 32'd0);
        check_output("reset_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        apply_stimulus(32'h40400000, 32'h3F800000, 0, cycles, res, busy_ok);
        check_output("three_minus_one_result", res, 32'h40000000);
        check_output("three_minus_one_cycles", 32'(cycles), 32'd7);
        check_output("three_minus_one_busy", {31'b0, busy_ok}, 32'd1);
        check_output("done_one_pulse", {31'b0, done}, 32'd0);
        check_output("idle_busy_low", {31'b0, busy}, 32'd0);

        run_case("equal_cancel", 32'h3F800000, 32'h3F800000, 32'h00000000, 5);

        apply_stimulus(32'h3F800000, 32'h3F7FFFFF, 0, cycles, res, busy_ok);
        check_output("norm24_result", res, 32'h33800000);
        check_output("norm24_cycles", 32'(cycles), 32'd31);
        check_output("norm24_busy", {31'b0, busy_ok}, 32'd1);

        run_case("effective_add", 32'h3F800000, 32'hBF800000, 32'h40000000, 7);
        run_case("inf_minus_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3);
        run_case("inf_minus_one", 32'h7F800000, 32'h3F800000, 32'h7F800000, 3);
        run_case("nan_operand", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 3);
        run_case("b_zero", 32'h3F800000, 32'h00000000, 32'h3F800000, 3);
        run_case("a_zero", 32'h00000000, 32'h3F800000, 32'hBF800000, 3);
        run_case("neg_minus_pos", 32'hC0000000, 32'h40400000, 32'hC0A00000, 7);
        run_case("two_minus_three", 32'h40000000, 32'h40400000, 32'hBF800000, 8);
        run_case("overflow_inf", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5);
        run_case("rounding", 32'h3F800000, 32'h33000000, ROUND_EXPECT, 8);

        // A second start raised mid-operation must not disturb the first result or produce another done
        apply_stimulus(32'h40400000, 32'h3F800000, 3, cycles, res, busy_ok);
        check_output("ignored_start_result", res, 32'h40000000);
        check_output("ignored_start_cycles", 32'(cycles), 32'd7);
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check_output("ignored_start_no_done", {31'b0, done_seen}, 32'd0);

        @(negedge clk);
        a     = 32'h3F800000;
        b     = 32'h3F7FFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check_output("pre_abort_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_output("abort_busy", {31'b0, busy}, 32'd0);
        check_output("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check_output("abort_no_done", {31'b0, done_seen}, 32'd0);
        check_output("abort_result", result, 32'h0);

        run_case("restart", 32'h40400000, 32'h3F800000, 32'h40000000, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
